// File: rtl/multiplier_seq_if.sv
// Start/done handshake bundle for the sequential multiplier.
// master: requester (drives start and operands, receives status and product).
// slave : multiplier (receives request, drives busy/done/product_hi/product_lo).
interface multiplier_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product_hi;
  logic [WIDTH-1:0] product_lo;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product_hi, product_lo
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product_hi, product_lo
  );
endinterface

// File: rtl/multiplier_seq.sv
// Iterative unsigned shift-add multiplier: product = multiplicand * multiplier.
// Latency: start accepted at edge E0, done pulses in the cycle after E(WIDTH);
//   next start accepted no earlier than E(WIDTH+2). No early termination.
// Backpressure: none; start is only sampled in IDLE, ignored in RUN/DONE.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus.slave  : start, multiplicand, multiplier in;
//                busy, done, product_hi, product_lo out (all registered)
module multiplier_seq #(
  parameter int WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  multiplier_seq_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [CW-1:0]      counter;
  logic [WIDTH-1:0]   a_q;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH:0]     sum;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   prod_hi_q;
  logic [WIDTH-1:0]   prod_lo_q;

  // One shift-add step. Conceptually the accumulator is 2*WIDTH+1 bits and
  // {sum, acc[WIDTH-1:0]} is shifted right by one; after that shift the top
  // bit is always zero, so it is not stored. The carry out of the add must
  // land in bit 2*WIDTH-1 -- losing it corrupts large products.
  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
    acc_nxt = acc[0] ? {sum, acc[WIDTH-1:1]}
                     : {1'b0, acc[2*WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      counter   <= '0;
      a_q       <= '0;
      acc       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      prod_hi_q <= '0;
      prod_lo_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.multiplicand;
            acc     <= {{WIDTH{1'b0}}, bus.multiplier};
            counter <= '0;
            busy_q  <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          acc     <= acc_nxt;
          counter <= counter + 1'b1;
          // Product registers only update here, so they hold the previous
          // result through the accepting edge and the whole RUN phase.
          if (counter == LAST) begin
            prod_hi_q <= acc_nxt[2*WIDTH-1:WIDTH];
            prod_lo_q <= acc_nxt[WIDTH-1:0];
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.product_hi = prod_hi_q;
  assign bus.product_lo = prod_lo_q;

endmodule

// File: tb/tb_multiplier_seq.sv
// Directed bench for multiplier_seq: latency, busy window, products, holding
// of results, back-to-back starts, ignored mid-run starts and async abort.
module tb_multiplier_seq;

  localparam int W = 16;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [W-1:0] last_hi;
  logic [W-1:0] last_lo;

  multiplier_seq_if #(.WIDTH(W)) bus ();

  multiplier_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full operation from idle: checks accept, busy window, latency,
  // result hold during RUN, the product and the single-cycle done pulse.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    int  cyc;
    int  busyc;
    bit  got;
    @(posedge clk); #1;
    bus.start        = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    @(posedge clk); #1;                 // E0 has been taken
    bus.start        = 1'b0;
    bus.multiplicand = 16'hA5A5;        // operands may change after accept
    bus.multiplier   = 16'h5A5A;
    check({tag, " busy_after_accept"}, 32'(bus.busy), 32'd1);
    cyc   = 0;
    busyc = 1;
    got   = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.done) begin
        got = 1'b1;
        check({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
      end else begin
        if (bus.busy) busyc++;
        if (cyc == 8) begin
          check({tag, " hold_hi"}, 32'(bus.product_hi), 32'(last_hi));
          check({tag, " hold_lo"}, 32'(bus.product_lo), 32'(last_lo));
        end
      end
    end
    check({tag, " latency"}, 32'(cyc), 32'd16);
    check({tag, " busy_cycles"}, 32'(busyc), 32'd16);
    check({tag, " hi"}, 32'(bus.product_hi), 32'(exp_hi));
    check({tag, " lo"}, 32'(bus.product_lo), 32'(exp_lo));
    last_hi = exp_hi;
    last_lo = exp_lo;
    @(posedge clk); #1;
    check({tag, " done_one_cycle"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int t;
    int nd;
    int since;
    int td [3];
    int ndone;

    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    last_hi          = '0;
    last_lo          = '0;
    rst_n            = 1'b0;

    // 1. reset release, idle
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset hi",   32'(bus.product_hi), 32'd0);
    check("reset lo",   32'(bus.product_lo), 32'd0);

    // 2-4. directed products
    run_op("11x28",  16'd11,   16'd28,   16'h0000, 16'd308);
    run_op("max",    16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001);
    run_op("0x37",   16'd0,    16'd37,   16'h0000, 16'h0000);
    run_op("37x0",   16'd37,   16'd0,    16'h0000, 16'h0000);
    run_op("1x1",    16'd1,    16'd1,    16'h0000, 16'h0001);

    // 5. start held high: back-to-back every 18 clks; operands wiggled
    // mid-RUN must not be picked up.
    @(posedge clk); #1;
    bus.start        = 1'b1;
    bus.multiplicand = 16'd6;
    bus.multiplier   = 16'd6;
    t     = 0;
    nd    = 0;
    since = -1;
    td    = '{0, 0, 0};
    while (nd < 3 && t < 100) begin
      @(posedge clk); #1;
      t++;
      if (since >= 0) since++;
      if (since == 5) begin
        bus.multiplicand = 16'd99;
        bus.multiplier   = 16'd99;
      end
      if (since == 8) begin
        bus.multiplicand = 16'd6;
        bus.multiplier   = 16'd6;
      end
      if (bus.done) begin
        td[nd] = t;
        check("b2b hi", 32'(bus.product_hi), 32'd0);
        check("b2b lo", 32'(bus.product_lo), 32'd36);
        nd++;
        if (nd == 1) since = 0;
      end
    end
    bus.start = 1'b0;
    check("b2b count", 32'(nd), 32'd3);
    check("b2b period1", 32'(td[1] - td[0]), 32'd18);
    check("b2b period2", 32'(td[2] - td[1]), 32'd18);
    repeat (3) @(posedge clk);
    last_hi = 16'd0;
    last_lo = 16'd36;

    // 6. async abort mid-RUN
    @(posedge clk); #1;
    bus.start        = 1'b1;
    bus.multiplicand = 16'd300;
    bus.multiplier   = 16'd300;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    check("abort hi",   32'(bus.product_hi), 32'd0);
    check("abort lo",   32'(bus.product_lo), 32'd0);
    ndone = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    #2 rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    check("abort no_done", 32'(ndone), 32'd0);
    check("abort idle_busy", 32'(bus.busy), 32'd0);
    check("abort idle_lo", 32'(bus.product_lo), 32'd0);
    last_hi = '0;
    last_lo = '0;
    run_op("300x300", 16'd300, 16'd300, 16'h0001, 16'h5F90);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
